// File: rtl/clock_time_controller_if.sv
// Bundle between the time controller and the seconds/minutes/hours counters and buttons.
// master drives the tick, buttons and counter state; slave is the controller.
interface clock_time_controller_if;
   logic       tick_1hz;
   logic       btn_mode;
   logic       btn_inc;
   logic       btn_dec;
   logic [5:0] sec_q;
   logic [5:0] min_q;
   logic [5:0] hour_q;
   logic       sec_cout;
   logic       min_cout;
   logic       sec_ce;
   logic       min_ce;
   logic       hour_ce;
   logic       sec_load_en;
   logic       min_load_en;
   logic       hour_load_en;
   logic [5:0] load_data;
   logic [1:0] edit_field;
   logic       blink;

   modport master (
      output tick_1hz, btn_mode, btn_inc, btn_dec,
      output sec_q, min_q, hour_q, sec_cout, min_cout,
      input  sec_ce, min_ce, hour_ce,
      input  sec_load_en, min_load_en, hour_load_en, load_data,
      input  edit_field, blink
   );

   modport slave (
      input  tick_1hz, btn_mode, btn_inc, btn_dec,
      input  sec_q, min_q, hour_q, sec_cout, min_cout,
      output sec_ce, min_ce, hour_ce,
      output sec_load_en, min_load_en, hour_load_en, load_data,
      output edit_field, blink
   );
endinterface

// File: rtl/clock_time_controller.sv
// Desktop clock sequencer: RUN-mode enable chain, SET-mode wrap-around loads,
// edit-field blink strobe and inactivity timeout back to RUN.
module clock_time_controller #(
   parameter int HOUR_MAX  = 23,
   parameter int MIN_MAX   = 59,
   parameter int BLINK_DIV = 25000000,
   parameter int TIMEOUT_S = 30
) (
   input logic                   clk,
   input logic                   rst_n,
   clock_time_controller_if.slave ctl
);
   localparam int BL_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam int TO_W = $clog2(TIMEOUT_S + 1);
   localparam logic [5:0]      HOUR_LIM = 6'(HOUR_MAX);
   localparam logic [5:0]      MIN_LIM  = 6'(MIN_MAX);
   localparam logic [BL_W-1:0] BL_LAST  = BL_W'(BLINK_DIV - 1);
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_S - 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2,
      SET_SEC  = 2'd3
   } state_t;

   state_t          state_reg, state_next;
   logic [1:0]      edit_field_reg;
   logic            blink_reg;
   logic [BL_W-1:0] blink_cnt_reg;
   logic [TO_W-1:0] timeout_cnt_reg;

   logic       btn_any, load_req, load_any, run_active;
   logic       sec_load, min_load, hour_load;
   logic [5:0] load_val;

   function automatic logic [5:0] wrap_inc(input logic [5:0] q, input logic [5:0] lim);
      return (q >= lim) ? 6'd0 : q + 6'd1;
   endfunction

   // Out-of-range values decrement to the limit rather than to q-1.
   function automatic logic [5:0] wrap_dec(input logic [5:0] q, input logic [5:0] lim);
      return (q == 6'd0 || q > lim) ? lim : q - 6'd1;
   endfunction

   assign btn_any    = ctl.btn_mode | ctl.btn_inc | ctl.btn_dec;
   assign load_req   = rst_n & (ctl.btn_inc ^ ctl.btn_dec) & ~ctl.btn_mode;
   assign run_active = rst_n & (state_reg == RUN);

   always_comb begin
      state_next = state_reg;
      if (ctl.btn_mode) begin
         case (state_reg)
            RUN:      state_next = SET_HOUR;
            SET_HOUR: state_next = SET_MIN;
            SET_MIN:  state_next = SET_SEC;
            default:  state_next = RUN;
         endcase
      end else if (state_reg != RUN && !btn_any && ctl.tick_1hz &&
                   timeout_cnt_reg == TO_LAST) begin
         state_next = RUN;
      end
   end

   always_comb begin
      sec_load  = 1'b0;
      min_load  = 1'b0;
      hour_load = 1'b0;
      load_val  = 6'd0;
      case (state_reg)
         SET_HOUR: begin
            hour_load = load_req;
            if (load_req)
               load_val = ctl.btn_inc ? wrap_inc(ctl.hour_q, HOUR_LIM)
                                      : wrap_dec(ctl.hour_q, HOUR_LIM);
         end
         SET_MIN: begin
            min_load = load_req;
            if (load_req)
               load_val = ctl.btn_inc ? wrap_inc(ctl.min_q, MIN_LIM)
                                      : wrap_dec(ctl.min_q, MIN_LIM);
         end
         SET_SEC:  sec_load = load_req;
         default:  ;
      endcase
   end

   assign load_any = sec_load | min_load | hour_load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= RUN;
         edit_field_reg  <= 2'd0;
         blink_reg       <= 1'b1;
         blink_cnt_reg   <= '0;
         timeout_cnt_reg <= '0;
      end else begin
         state_reg      <= state_next;
         edit_field_reg <= 2'(state_next);

         if (state_next == RUN || btn_any)
            timeout_cnt_reg <= '0;
         else if (ctl.tick_1hz)
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;

         // Any field change or load restarts the strobe in the visible phase.
         if (state_next == RUN || state_next != state_reg || load_any) begin
            blink_cnt_reg <= '0;
            blink_reg     <= 1'b1;
         end else if (blink_cnt_reg == BL_LAST) begin
            blink_cnt_reg <= '0;
            blink_reg     <= ~blink_reg;
         end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
         end
      end
   end

   assign ctl.sec_ce       = run_active & ctl.tick_1hz;
   assign ctl.min_ce       = run_active & ctl.tick_1hz & ctl.sec_cout;
   assign ctl.hour_ce      = run_active & ctl.tick_1hz & ctl.sec_cout & ctl.min_cout;
   assign ctl.sec_load_en  = sec_load;
   assign ctl.min_load_en  = min_load;
   assign ctl.hour_load_en = hour_load;
   assign ctl.load_data    = load_val;
   assign ctl.edit_field   = edit_field_reg;
   assign ctl.blink        = blink_reg;
endmodule

// File: tb/tb_clock_time_controller.sv
// Directed bench for clock_time_controller with short blink and timeout periods.
module tb_clock_time_controller;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   clock_time_controller_if bus ();

   clock_time_controller #(
      .HOUR_MAX (23),
      .MIN_MAX  (59),
      .BLINK_DIV(4),
      .TIMEOUT_S(3)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .ctl  (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.tick_1hz = 1'b0;
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
      bus.btn_dec  = 1'b0;
   endtask

   task automatic pulse_and_step(input logic t, input logic m, input logic i, input logic d);
      bus.tick_1hz = t;
      bus.btn_mode = m;
      bus.btn_inc  = i;
      bus.btn_dec  = d;
      step();
      clear_inputs();
      #1;
   endtask

   task automatic check_loads(input string tag, input int h, input int m, input int s, input int data);
      check_eq({tag, "_hour_ld"}, int'(bus.hour_load_en), h);
      check_eq({tag, "_min_ld"},  int'(bus.min_load_en), m);
      check_eq({tag, "_sec_ld"},  int'(bus.sec_load_en), s);
      check_eq({tag, "_data"},    int'(bus.load_data), data);
   endtask

   task automatic check_ces(input string tag, input int s, input int m, input int h);
      check_eq({tag, "_sec_ce"},  int'(bus.sec_ce), s);
      check_eq({tag, "_min_ce"},  int'(bus.min_ce), m);
      check_eq({tag, "_hour_ce"}, int'(bus.hour_ce), h);
   endtask

   initial begin
      clear_inputs();
      bus.sec_q = 6'd0; bus.min_q = 6'd0; bus.hour_q = 6'd0;
      bus.sec_cout = 1'b0; bus.min_cout = 1'b0;

      // Reset state, with a tick present to show enables are gated.
      #2 rst_n = 1'b0;
      bus.tick_1hz = 1'b1;
      #1;
      check_eq("rst_edit", int'(bus.edit_field), 0);
      check_eq("rst_blink", int'(bus.blink), 1);
      check_ces("rst", 0, 0, 0);
      check_loads("rst", 0, 0, 0, 0);
      bus.tick_1hz = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();

      // Full rollover in RUN.
      bus.sec_q = 6'd59; bus.min_q = 6'd59; bus.hour_q = 6'd23;
      bus.sec_cout = 1'b1; bus.min_cout = 1'b1; bus.tick_1hz = 1'b1;
      #1;
      check_ces("roll", 1, 1, 1);
      check_loads("roll", 0, 0, 0, 0);
      step(); clear_inputs();
      bus.min_cout = 1'b0; bus.tick_1hz = 1'b1;
      #1;
      check_ces("sec_carry", 1, 1, 0);
      bus.tick_1hz = 1'b0; bus.btn_inc = 1'b1;
      #1;
      check_ces("no_tick", 0, 0, 0);
      check_loads("run_inc", 0, 0, 0, 0);
      step(); clear_inputs();
      bus.sec_cout = 1'b0;

      // Enter SET_HOUR and watch the blink strobe.
      pulse_and_step(1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("sethour_edit", int'(bus.edit_field), 1);
      check_eq("sethour_blink0", int'(bus.blink), 1);
      repeat (3) step();
      check_eq("blink_hold", int'(bus.blink), 1);
      step();
      check_eq("blink_toggle", int'(bus.blink), 0);

      // Hour wraps.
      bus.hour_q = 6'd23; bus.btn_inc = 1'b1;
      #1;
      check_loads("h23_inc", 1, 0, 0, 0);
      step(); clear_inputs(); #1;
      check_eq("load_blink", int'(bus.blink), 1);
      bus.hour_q = 6'd0; bus.btn_dec = 1'b1;
      #1;
      check_loads("h0_dec", 1, 0, 0, 23);
      step(); clear_inputs();
      bus.hour_q = 6'd5; bus.btn_inc = 1'b1;
      #1;
      check_loads("h5_inc", 1, 0, 0, 6);
      step();
      bus.hour_q = 6'd6;
      #1;
      check_loads("h6_inc_b2b", 1, 0, 0, 7);
      step(); clear_inputs();
      bus.hour_q = 6'd5; bus.btn_dec = 1'b1;
      #1;
      check_loads("h5_dec", 1, 0, 0, 4);
      step(); clear_inputs();
      bus.hour_q = 6'd30; bus.btn_inc = 1'b1;
      #1;
      check_loads("h30_inc", 1, 0, 0, 0);
      bus.btn_inc = 1'b0; bus.btn_dec = 1'b1;
      #1;
      check_loads("h30_dec", 1, 0, 0, 23);
      step(); clear_inputs();

      // SET_MIN: load during a tick, timekeeping frozen.
      pulse_and_step(1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("setmin_edit", int'(bus.edit_field), 2);
      bus.min_q = 6'd59; bus.sec_cout = 1'b1; bus.min_cout = 1'b1;
      bus.btn_inc = 1'b1; bus.tick_1hz = 1'b1;
      #1;
      check_loads("m59_inc", 0, 1, 0, 0);
      check_ces("frozen", 0, 0, 0);
      step(); clear_inputs();
      bus.sec_cout = 1'b0; bus.min_cout = 1'b0;
      bus.min_q = 6'd0; bus.btn_dec = 1'b1;
      #1;
      check_loads("m0_dec", 0, 1, 0, 59);
      step(); clear_inputs();
      bus.min_q = 6'd20; bus.btn_inc = 1'b1; bus.btn_dec = 1'b1;
      #1;
      check_loads("inc_dec", 0, 0, 0, 0);
      step(); clear_inputs();
      bus.btn_mode = 1'b1; bus.btn_inc = 1'b1;
      #1;
      check_loads("mode_inc", 0, 0, 0, 0);
      step(); clear_inputs(); #1;
      check_eq("setsec_edit", int'(bus.edit_field), 3);

      // Seconds zeroing and exit to RUN.
      bus.sec_q = 6'd42; bus.btn_dec = 1'b1;
      #1;
      check_loads("s42_dec", 0, 0, 1, 0);
      step(); clear_inputs();
      pulse_and_step(1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("exit_edit", int'(bus.edit_field), 0);
      bus.tick_1hz = 1'b1;
      #1;
      check_ces("exit_tick", 1, 0, 0);
      step(); clear_inputs();

      // Plain timeout after three ticks.
      pulse_and_step(1'b0, 1'b1, 1'b0, 1'b0);
      pulse_and_step(1'b1, 1'b0, 1'b0, 1'b0);
      pulse_and_step(1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("to_2ticks", int'(bus.edit_field), 1);
      pulse_and_step(1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("to_3ticks", int'(bus.edit_field), 0);

      // Timeout restarted by a button after the second tick.
      pulse_and_step(1'b0, 1'b1, 1'b0, 1'b0);
      pulse_and_step(1'b1, 1'b0, 1'b0, 1'b0);
      pulse_and_step(1'b1, 1'b0, 1'b0, 1'b0);
      pulse_and_step(1'b0, 1'b0, 1'b1, 1'b0);
      pulse_and_step(1'b1, 1'b0, 1'b0, 1'b0);
      pulse_and_step(1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("to_restart_2", int'(bus.edit_field), 1);
      // Button on the expiring tick wins over the timeout.
      pulse_and_step(1'b1, 1'b0, 1'b1, 1'b0);
      check_eq("to_btn_wins", int'(bus.edit_field), 1);
      repeat (2) pulse_and_step(1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("to_restart_2b", int'(bus.edit_field), 1);
      pulse_and_step(1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("to_restart_3", int'(bus.edit_field), 0);

      // Asynchronous reset mid-SET_MIN with a pending inc.
      pulse_and_step(1'b0, 1'b1, 1'b0, 1'b0);
      pulse_and_step(1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("pre_rst_edit", int'(bus.edit_field), 2);
      repeat (4) step();
      check_eq("pre_rst_blink", int'(bus.blink), 0);
      bus.btn_inc = 1'b1;
      #1;
      check_eq("pre_rst_load", int'(bus.min_load_en), 1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("async_edit", int'(bus.edit_field), 0);
      check_eq("async_blink", int'(bus.blink), 1);
      check_loads("async", 0, 0, 0, 0);
      clear_inputs();
      step();
      rst_n = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
